// File: rtl/wb_mem_slave.sv
// Wishbone-style word-addressed memory responder with configurable wait states.
// Optional write protection port i_wprot is enabled by defining WB_MEM_WPROT_EN.
module wb_mem_slave #(
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_wb_addr,
  input  logic        i_wb_cyc,
  input  logic [3:0]  i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_dat,
`ifdef WB_MEM_WPROT_EN
  input  logic        i_wprot,
`endif
  output logic [31:0] o_wb_dat,
  output logic        o_wb_ack,
  output logic        o_wb_err
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP, ST_DONE} state_t;

  state_t                  state_r, state_s;
  logic [3:0]              cnt_r, cnt_s;
  logic [ADDR_WIDTH-1:0]   word_r;
  logic                    bad_r;
  logic                    we_r;
  logic [3:0]              stb_r;
  logic [31:0]             dat_r;
  logic [31:0]             mem_r [0:DEPTH-1];

  logic [31:0]             off_s;
  logic                    bad_s;
  logic                    capture_s;
  logic                    ack_s;
  logic                    err_s;
  logic                    wr_en_s;
  logic                    prot_s;

  function automatic logic [31:0] lane_mask(input logic [3:0] stb);
    lane_mask = {{8{stb[3]}}, {8{stb[2]}}, {8{stb[1]}}, {8{stb[0]}}};
  endfunction

  // Unsigned offset into the window; addresses below the base wrap high and fail the range test.
  assign off_s = i_wb_addr - BASE_ADDR;
  assign bad_s = ((off_s >> (ADDR_WIDTH + 2)) != 32'd0) || (i_wb_stb == 4'b0000);

`ifdef WB_MEM_WPROT_EN
  assign prot_s = we_r & i_wprot;
`else
  assign prot_s = 1'b0;
`endif

  // Next-state and response decode.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    capture_s = 1'b0;
    ack_s     = 1'b0;
    err_s     = 1'b0;
    wr_en_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_wb_cyc) begin
          capture_s = 1'b1;
          cnt_s     = WAIT_CNT;
          state_s   = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!i_wb_cyc) begin
          state_s = ST_IDLE;
          cnt_s   = 4'd0;
        end else if (cnt_r <= 4'd1) begin
          state_s = ST_RESP;
          cnt_s   = 4'd0;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      ST_RESP: begin
        if (!i_wb_cyc) begin
          state_s = ST_IDLE;
        end else if (bad_r || prot_s) begin
          err_s   = 1'b1;
          state_s = ST_DONE;
        end else begin
          ack_s   = 1'b1;
          wr_en_s = we_r;
          state_s = ST_DONE;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, counter and registered bus outputs.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 4'd0;
      o_wb_ack <= 1'b0;
      o_wb_err <= 1'b0;
      o_wb_dat <= 32'd0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      o_wb_ack <= ack_s;
      o_wb_err <= err_s;
      if (ack_s && !we_r) begin
        o_wb_dat <= mem_r[word_r];
      end else begin
        o_wb_dat <= o_wb_dat;
      end
    end
  end

  // Request capture; later input changes are ignored until the next capture.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      word_r <= '0;
      bad_r  <= 1'b0;
      we_r   <= 1'b0;
      stb_r  <= 4'b0000;
      dat_r  <= 32'd0;
    end else if (capture_s) begin
      word_r <= off_s[ADDR_WIDTH+1:2];
      bad_r  <= bad_s;
      we_r   <= i_wb_we;
      stb_r  <= i_wb_stb;
      dat_r  <= i_wb_dat;
    end else begin
      word_r <= word_r;
      bad_r  <= bad_r;
      we_r   <= we_r;
      stb_r  <= stb_r;
      dat_r  <= dat_r;
    end
  end

  // Byte-lane write, committed at the edge that raises ack; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (i_reset && wr_en_s) begin
      mem_r[word_r] <= (mem_r[word_r] & ~lane_mask(stb_r)) | (dat_r & lane_mask(stb_r));
    end
  end

endmodule

// File: tb/tb_wb_mem_slave.sv
// Directed self-checking bench for wb_mem_slave (default build plus a zero-wait-state instance).
module tb_wb_mem_slave;

  logic        clk;
  logic        rst_n;
  logic [31:0] wb_addr;
  logic        wb_cyc;
  logic        wb_cyc0;
  logic [3:0]  wb_stb;
  logic        wb_we;
  logic [31:0] wb_dat;
  logic        wprot;
  logic [31:0] dat1, dat0;
  logic        ack1, ack0, err1, err0;

  int          checks;
  int          errors;

  logic        r_ack, r_err;
  logic [31:0] r_dat;
  int          r_lat, r_extra;

  wb_mem_slave dut (
    .i_clk     (clk),
    .i_reset   (rst_n),
    .i_wb_addr (wb_addr),
    .i_wb_cyc  (wb_cyc),
    .i_wb_stb  (wb_stb),
    .i_wb_we   (wb_we),
    .i_wb_dat  (wb_dat),
`ifdef WB_MEM_WPROT_EN
    .i_wprot   (wprot),
`endif
    .o_wb_dat  (dat1),
    .o_wb_ack  (ack1),
    .o_wb_err  (err1)
  );

  wb_mem_slave #(.WAIT_STATES(0)) dut0 (
    .i_clk     (clk),
    .i_reset   (rst_n),
    .i_wb_addr (wb_addr),
    .i_wb_cyc  (wb_cyc0),
    .i_wb_stb  (wb_stb),
    .i_wb_we   (wb_we),
    .i_wb_dat  (wb_dat),
`ifdef WB_MEM_WPROT_EN
    .i_wprot   (wprot),
`endif
    .o_wb_dat  (dat0),
    .o_wb_ack  (ack0),
    .o_wb_err  (err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transfer; master keeps cyc through the edge after ack, then releases.
  task automatic xfer(input bit sel, input logic [31:0] a, input logic w,
                      input logic [3:0] s, input logic [31:0] d,
                      output logic ackv, output logic errv, output logic [31:0] rdv,
                      output int latv, output int extrav);
    wb_addr = a;
    wb_we   = w;
    wb_stb  = s;
    wb_dat  = d;
    if (sel) wb_cyc0 = 1'b1;
    else     wb_cyc  = 1'b1;
    ackv = 1'b0; errv = 1'b0; rdv = 32'd0; latv = 0; extrav = 0;
    @(posedge clk); #1;
    for (int k = 1; k <= 20 && latv == 0; k++) begin
      @(posedge clk); #1;
      if ((sel ? (ack0 | err0) : (ack1 | err1)) === 1'b1) begin
        latv = k;
        ackv = sel ? ack0 : ack1;
        errv = sel ? err0 : err1;
        rdv  = sel ? dat0 : dat1;
      end
    end
    @(posedge clk); #1;
    extrav = int'(sel ? (ack0 | err0) : (ack1 | err1));
    wb_cyc = 1'b0; wb_cyc0 = 1'b0; wb_stb = 4'b0000; wb_we = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      extrav += int'(sel ? (ack0 | err0) : (ack1 | err1));
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; wb_addr = 32'd0; wb_cyc = 1'b0; wb_cyc0 = 1'b0;
    wb_stb = 4'b0000; wb_we = 1'b0; wb_dat = 32'd0; wprot = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {31'd0, ack1}, 32'd0);
    chk("rst_err", {31'd0, err1}, 32'd0);
    chk("rst_dat", dat1, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    xfer(1'b0, 32'h10, 1'b1, 4'b1111, 32'hDEADBEEF, r_ack, r_err, r_dat, r_lat, r_extra);
    chk("wr_full_ack", {31'd0, r_ack}, 32'd1);
    chk("wr_full_err", {31'd0, r_err}, 32'd0);
    chk("wr_full_lat", 32'(r_lat), 32'd2);
    chk("wr_full_single_pulse", 32'(r_extra), 32'd0);
    xfer(1'b0, 32'h10, 1'b0, 4'b1111, 32'd0, r_ack, r_err, r_dat, r_lat, r_extra);
    chk("rd_full_ack", {31'd0, r_ack}, 32'd1);
    chk("rd_full_lat", 32'(r_lat), 32'd2);
    chk("rd_full_dat", r_dat, 32'hDEADBEEF);
    chk("rd_full_single_pulse", 32'(r_extra), 32'd0);

    xfer(1'b0, 32'h10, 1'b1, 4'b0001, 32'h000000AA, r_ack, r_err, r_dat, r_lat, r_extra);
    chk("wr_lane0_ack", {31'd0, r_ack}, 32'd1);
    xfer(1'b0, 32'h10, 1'b0, 4'b0001, 32'd0, r_ack, r_err, r_dat, r_lat, r_extra);
    chk("rd_lane0_dat", r_dat, 32'hDEADBEAA);
    xfer(1'b0, 32'h10, 1'b1, 4'b1000, 32'h11000000, r_ack, r_err, r_dat, r_lat, r_extra);
    chk("wr_lane3_dat_unchanged", dat1, 32'hDEADBEAA);
    xfer(1'b0, 32'h10, 1'b0, 4'b1111, 32'd0, r_ack, r_err, r_dat, r_lat, r_extra);
    chk("rd_lane3_dat", r_dat, 32'h11ADBEAA);

    xfer(1'b0, 32'h0, 1'b1, 4'b1111, 32'h55AA55AA, r_ack, r_err, r_dat, r_lat, r_extra);
    chk("wr_word0_ack", {31'd0, r_ack}, 32'd1);
    xfer(1'b0, 32'h1000, 1'b0, 4'b1111, 32'd0, r_ack, r_err, r_dat, r_lat, r_extra);
    chk("oor_rd_err", {31'd0, r_err}, 32'd1);
    chk("oor_rd_ack", {31'd0, r_ack}, 32'd0);
    chk("oor_rd_lat", 32'(r_lat), 32'd2);
    chk("oor_rd_dat_held", r_dat, 32'h11ADBEAA);
    chk("oor_rd_single_pulse", 32'(r_extra), 32'd0);
    xfer(1'b0, 32'h1000, 1'b1, 4'b1111, 32'hFFFFFFFF, r_ack, r_err, r_dat, r_lat, r_extra);
    chk("oor_wr_err", {31'd0, r_err}, 32'd1);
    xfer(1'b0, 32'h0, 1'b0, 4'b1111, 32'd0, r_ack, r_err, r_dat, r_lat, r_extra);
    chk("no_alias_word0", r_dat, 32'h55AA55AA);

    xfer(1'b0, 32'h10, 1'b0, 4'b0000, 32'd0, r_ack, r_err, r_dat, r_lat, r_extra);
    chk("stb0_err", {31'd0, r_err}, 32'd1);
    chk("stb0_ack", {31'd0, r_ack}, 32'd0);
    chk("stb0_lat", 32'(r_lat), 32'd2);

    xfer(1'b0, 32'h20, 1'b1, 4'b1111, 32'hCAFEF00D, r_ack, r_err, r_dat, r_lat, r_extra);
    chk("wr_0x20_ack", {31'd0, r_ack}, 32'd1);
    wb_addr = 32'h20; wb_we = 1'b1; wb_stb = 4'b1111; wb_dat = 32'h12345678; wb_cyc = 1'b1;
    @(posedge clk); #1;
    wb_cyc = 1'b0;
    r_extra = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      r_extra += int'(ack1 | err1);
    end
    wb_we = 1'b0; wb_stb = 4'b0000;
    chk("abort_no_resp", 32'(r_extra), 32'd0);
    xfer(1'b0, 32'h20, 1'b0, 4'b1111, 32'd0, r_ack, r_err, r_dat, r_lat, r_extra);
    chk("abort_no_write", r_dat, 32'hCAFEF00D);

    wb_addr = 32'h10; wb_we = 1'b1; wb_stb = 4'b1111; wb_dat = 32'h0; wb_cyc = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_wait_ack", {31'd0, ack1}, 32'd0);
    chk("rst_wait_err", {31'd0, err1}, 32'd0);
    chk("rst_wait_dat", dat1, 32'd0);
    wb_cyc = 1'b0; wb_we = 1'b0; wb_stb = 4'b0000;
    rst_n = 1'b1;
    r_extra = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      r_extra += int'(ack1 | err1);
    end
    chk("rst_wait_no_resp", 32'(r_extra), 32'd0);
    xfer(1'b0, 32'h10, 1'b0, 4'b1111, 32'd0, r_ack, r_err, r_dat, r_lat, r_extra);
    chk("mem_kept_over_reset", r_dat, 32'h11ADBEAA);

`ifdef WB_MEM_WPROT_EN
    wprot = 1'b1;
    xfer(1'b0, 32'h10, 1'b1, 4'b1111, 32'h0, r_ack, r_err, r_dat, r_lat, r_extra);
    chk("wprot_err", {31'd0, r_err}, 32'd1);
    chk("wprot_ack", {31'd0, r_ack}, 32'd0);
    xfer(1'b0, 32'h10, 1'b0, 4'b1111, 32'd0, r_ack, r_err, r_dat, r_lat, r_extra);
    chk("wprot_rd_ok", {31'd0, r_ack}, 32'd1);
    chk("wprot_unchanged", r_dat, 32'h11ADBEAA);
    wprot = 1'b0;
`endif

    xfer(1'b1, 32'h40, 1'b1, 4'b1111, 32'h0BADF00D, r_ack, r_err, r_dat, r_lat, r_extra);
    chk("ws0_wr_ack", {31'd0, r_ack}, 32'd1);
    chk("ws0_wr_lat", 32'(r_lat), 32'd1);
    chk("ws0_single_pulse", 32'(r_extra), 32'd0);
    xfer(1'b1, 32'h40, 1'b0, 4'b1111, 32'd0, r_ack, r_err, r_dat, r_lat, r_extra);
    chk("ws0_rd_lat", 32'(r_lat), 32'd1);
    chk("ws0_rd_dat", r_dat, 32'h0BADF00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
